// File: rtl/fsqrt_table_loader.sv
// Streams a packed byte image into the fsqrt coefficient RAM: 5 bytes per 36-bit word,
// followed by one XOR checksum byte that is verified before reporting done.
module fsqrt_table_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [DATA_W-9:0]   asm_q;
  logic [7:0]          xsum;
  logic                accept, word_end, last_word, load_go;
  logic [DATA_W-1:0]   word_nxt;

  assign in_ready  = (state == LOAD) || (state == CHECK);
  assign busy      = in_ready;
  assign done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign load_go   = start && ((state == IDLE) || (state == DONE));
  assign word_end  = (state == LOAD) && accept && (byte_cnt == 3'd4);
  assign last_word = (word_idx == ADDR_W'(DEPTH - 1));
  // Shifting whole bytes through a DATA_W window drops byte0's high nibble for free.
  assign word_nxt  = {asm_q, in_data};

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)                  state_nxt = LOAD;
      LOAD:       if (word_end && last_word)  state_nxt = CHECK;
      CHECK:      if (accept)                 state_nxt = DONE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      byte_cnt <= '0;
      word_idx <= '0;
      asm_q    <= '0;
      xsum     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      chk_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (load_go) begin
        byte_cnt <= '0;
        word_idx <= '0;
        asm_q    <= '0;
        xsum     <= '0;
        chk_err  <= 1'b0;
      end
      if ((state == LOAD) && accept) begin
        xsum     <= xsum ^ in_data;
        asm_q    <= word_nxt[DATA_W-9:0];
        byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
      end
      if (word_end) begin
        wr_en    <= 1'b1;
        wr_addr  <= word_idx;
        wr_data  <= word_nxt;
        word_idx <= word_idx + ADDR_W'(1);
      end
      if ((state == CHECK) && accept)
        chk_err <= (in_data != xsum);
    end
  end

endmodule
